// File: rtl/aesl_deadlock_pkg.sv
// aesl_deadlock_pkg: shared types and defaults for the deadlock reporter
package aesl_deadlock_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMING = 2'd1,
      REPORT = 2'd2,
      HOLD   = 2'd3
   } state_e;

   localparam int DEF_AXIS_NUM     = 3;
   localparam int DEF_THRESHOLD    = 16;
   localparam int DEF_CNT_WIDTH    = 16;
   localparam int DEF_TS_WIDTH     = 32;
   localparam int REPORT_CNT_WIDTH = 8;

   function automatic logic [REPORT_CNT_WIDTH-1:0] sat_inc(input logic [REPORT_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/aesl_deadlock_stall_timer.sv
// aesl_deadlock_stall_timer: counts consecutive block cycles and flags persistence
module aesl_deadlock_stall_timer
   import aesl_deadlock_pkg::*;
#(
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic block_i,
   input  logic restart_i,
   output logic expired_o
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(THRESHOLD - 1);

   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   assign expired_o = block_i && !restart_i && (stall_cnt_q == LAST);

   // any low sample, a restart or qualification itself returns the count to zero
   always_comb begin
      stall_cnt_d = (restart_i || !block_i || expired_o) ? '0 : stall_cnt_q + 1'b1;
   end

   // stall counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

endmodule

// File: rtl/aesl_deadlock_reporter.sv
// aesl_deadlock_reporter: qualifies a deadlock verdict and issues one timestamped report per episode
module aesl_deadlock_reporter
   import aesl_deadlock_pkg::*;
#(
   parameter int AXIS_NUM  = DEF_AXIS_NUM,
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int TS_WIDTH  = DEF_TS_WIDTH
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        block,
   input  logic [AXIS_NUM-1:0]         axis_block_sigs,
   input  logic                        clear,
   output logic                        report_valid,
   input  logic                        report_ready,
   output logic [TS_WIDTH-1:0]         report_ts,
   output logic [AXIS_NUM-1:0]         report_axis,
   output logic [REPORT_CNT_WIDTH-1:0] report_count,
   output logic                        deadlock
);

   state_e                        state_q, state_d;
   logic [TS_WIDTH-1:0]           cycle_cnt_q, cycle_cnt_d;
   logic [TS_WIDTH-1:0]           report_ts_q, report_ts_d;
   logic [AXIS_NUM-1:0]           report_axis_q, report_axis_d;
   logic [REPORT_CNT_WIDTH-1:0]   report_count_q, report_count_d;
   logic                          report_valid_q, report_valid_d;
   logic                          deadlock_q, deadlock_d;
   logic                          expired, restart, accept, load;

   assign restart = clear || (state_q == REPORT) || (state_q == HOLD);

   aesl_deadlock_stall_timer #(
      .THRESHOLD (THRESHOLD),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .clk_i     (clock),
      .rst_i     (reset),
      .block_i   (block),
      .restart_i (restart),
      .expired_o (expired)
   );

   // next state, snapshot capture and handshake accounting; clear overrides everything
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, ARMING: state_d = expired ? REPORT : (block ? ARMING : IDLE);
         REPORT:       state_d = (report_valid_q && report_ready) ? HOLD : REPORT;
         HOLD:         state_d = HOLD;
      endcase
      if (clear) state_d = IDLE;
      accept         = (state_q == REPORT) && report_valid_q && report_ready && !clear;
      load           = (state_d == REPORT) && (state_q != REPORT);
      cycle_cnt_d    = cycle_cnt_q + 1'b1;
      report_ts_d    = load ? cycle_cnt_q : report_ts_q;
      report_axis_d  = load ? axis_block_sigs : report_axis_q;
      report_count_d = accept ? sat_inc(report_count_q) : report_count_q;
      report_valid_d = (state_d == REPORT);
      deadlock_d     = (state_d == REPORT) || (state_d == HOLD);
   end

   // state and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         cycle_cnt_q    <= '0;
         report_ts_q    <= '0;
         report_axis_q  <= '0;
         report_count_q <= '0;
         report_valid_q <= 1'b0;
         deadlock_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cycle_cnt_q    <= cycle_cnt_d;
         report_ts_q    <= report_ts_d;
         report_axis_q  <= report_axis_d;
         report_count_q <= report_count_d;
         report_valid_q <= report_valid_d;
         deadlock_q     <= deadlock_d;
      end
   end

   assign report_valid = report_valid_q;
   assign report_ts    = report_ts_q;
   assign report_axis  = report_axis_q;
   assign report_count = report_count_q;
   assign deadlock     = deadlock_q;

endmodule

// File: tb/tb_aesl_deadlock_reporter.sv
// tb_aesl_deadlock_reporter: scoreboard bench for the deadlock reporter at THRESHOLD 16 and 1
module tb_aesl_deadlock_reporter;

   typedef struct {
      logic [31:0] ts;
      logic [2:0]  axis;
   } rep_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        a_block = 1'b0, a_clear = 1'b0, a_ready = 1'b0;
   logic [2:0]  a_axis = 3'b000;
   logic        a_valid, a_dl;
   logic [31:0] a_ts;
   logic [2:0]  a_raxis;
   logic [7:0]  a_count;
   logic        b_block = 1'b0, b_clear = 1'b0, b_ready = 1'b0;
   logic [2:0]  b_axis = 3'b000;
   logic        b_valid, b_dl;
   logic [31:0] b_ts;
   logic [2:0]  b_raxis;
   logic [7:0]  b_count;
   logic [31:0] cyc;
   logic [31:0] exp_ts;
   int          vectors = 0;
   int          miscompares = 0;
   rep_t        qa[$];
   rep_t        qb[$];
   rep_t        ra, rb;

   always #5 clock = ~clock;

   aesl_deadlock_reporter u_a (
      .clock           (clock),
      .reset           (reset),
      .block           (a_block),
      .axis_block_sigs (a_axis),
      .clear           (a_clear),
      .report_valid    (a_valid),
      .report_ready    (a_ready),
      .report_ts       (a_ts),
      .report_axis     (a_raxis),
      .report_count    (a_count),
      .deadlock        (a_dl)
   );

   aesl_deadlock_reporter #(.THRESHOLD(1)) u_b (
      .clock           (clock),
      .reset           (reset),
      .block           (b_block),
      .axis_block_sigs (b_axis),
      .clear           (b_clear),
      .report_valid    (b_valid),
      .report_ready    (b_ready),
      .report_ts       (b_ts),
      .report_axis     (b_raxis),
      .report_count    (b_count),
      .deadlock        (b_dl)
   );

   always @(posedge clock) cyc <= reset ? 32'd0 : cyc + 32'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      if (!reset && a_valid && a_ready && !a_clear) begin
         if (qa.size() == 0) chk("a_unexpected_report", 32'd1, 32'd0);
         else begin
            ra = qa.pop_front();
            chk("a_report_ts", a_ts, ra.ts);
            chk("a_report_axis", {29'd0, a_raxis}, {29'd0, ra.axis});
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && b_valid && b_ready && !b_clear) begin
         if (qb.size() == 0) chk("b_unexpected_report", 32'd1, 32'd0);
         else begin
            rb = qb.pop_front();
            chk("b_report_ts", b_ts, rb.ts);
            chk("b_report_axis", {29'd0, b_raxis}, {29'd0, rb.axis});
         end
      end
   end

   task automatic b_episode(input logic [2:0] ax, input int n);
      b_axis  = ax;
      b_block = 1'b1;
      exp_ts  = cyc;
      step();
      b_block = 1'b0;
      chk("b_pulse_valid", b_valid, 1'b1);
      qb.push_back('{exp_ts, ax});
      b_ready = 1'b1;
      step();
      b_ready = 1'b0;
      chk("b_count", b_count, (n > 255) ? 32'd255 : 32'(n));
      b_clear = 1'b1;
      step();
      b_clear = 1'b0;
      chk("b_cleared", b_dl, 1'b0);
   endtask

   initial begin
      step(2);
      reset = 1'b0;
      chk("rst_valid", a_valid, 1'b0);
      chk("rst_deadlock", a_dl, 1'b0);
      chk("rst_count", a_count, 32'd0);
      chk("rst_ts", a_ts, 32'd0);
      chk("rst_axis", a_raxis, 32'd0);
      a_axis  = 3'b101;
      a_block = 1'b1;
      step(15);
      a_block = 1'b0;
      step();
      chk("a_short_burst_valid", a_valid, 1'b0);
      a_block = 1'b1;
      step(15);
      chk("a_15_high_valid", a_valid, 1'b0);
      exp_ts = cyc;
      step();
      chk("a_16_high_valid", a_valid, 1'b1);
      chk("a_16_high_deadlock", a_dl, 1'b1);
      chk("a_ts_direct", a_ts, exp_ts);
      qa.push_back('{exp_ts, 3'b101});
      for (int i = 0; i < 5; i++) begin
         a_block = i[0];
         a_axis  = 3'b010;
         step();
         chk("a_stall_valid", a_valid, 1'b1);
         chk("a_stall_ts", a_ts, exp_ts);
         chk("a_stall_axis", a_raxis, 32'b101);
      end
      a_ready = 1'b1;
      step();
      a_ready = 1'b0;
      chk("a_post_hs_valid", a_valid, 1'b0);
      chk("a_post_hs_deadlock", a_dl, 1'b1);
      chk("a_post_hs_count", a_count, 32'd1);
      a_block = 1'b1;
      step(20);
      chk("a_hold_valid", a_valid, 1'b0);
      chk("a_hold_deadlock", a_dl, 1'b1);
      a_clear = 1'b1;
      a_block = 1'b0;
      step();
      a_clear = 1'b0;
      chk("a_clear_deadlock", a_dl, 1'b0);
      a_axis  = 3'b111;
      a_block = 1'b1;
      step(16);
      chk("a_second_valid", a_valid, 1'b1);
      a_block = 1'b0;
      a_clear = 1'b1;
      a_ready = 1'b1;
      step();
      a_clear = 1'b0;
      a_ready = 1'b0;
      chk("a_clr_hs_valid", a_valid, 1'b0);
      chk("a_clr_hs_deadlock", a_dl, 1'b0);
      chk("a_clr_hs_count", a_count, 32'd1);
      a_block = 1'b1;
      step(15);
      chk("a_idle_after_clr", a_valid, 1'b0);
      step();
      chk("a_third_valid", a_valid, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("a_rst_valid", a_valid, 1'b0);
      chk("a_rst_deadlock", a_dl, 1'b0);
      chk("a_rst_count", a_count, 32'd0);
      chk("a_rst_ts", a_ts, 32'd0);
      chk("a_rst_axis", a_raxis, 32'd0);
      a_axis = 3'b011;
      step(16);
      chk("a_post_rst_valid", a_valid, 1'b1);
      qa.push_back('{32'd15, 3'b011});
      a_block = 1'b0;
      a_ready = 1'b1;
      step();
      a_ready = 1'b0;
      chk("a_post_rst_count", a_count, 32'd1);
      for (int i = 1; i <= 256; i++) b_episode(3'(i), i);
      chk("qa_drained", qa.size(), 32'd0);
      chk("qb_drained", qb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/aesl_deadlock_reporter.md
# aesl_deadlock_reporter

Consumes the 1-bit `block` verdict of the top-level co-simulation deadlock monitor for an HLS instance, together with that instance's per-channel AXIS block vector. It qualifies `block` against a persistence threshold, snapshots which AXIS channels were stalled, and timestamps the event. It then presents a one-shot report over a valid/ready handshake to the testbench logger, and keeps a sticky `deadlock` flag until explicitly cleared. It sits directly downstream of the monitor tree in the co-simulation wrapper.

## Interface
Parameters:
- `AXIS_NUM`, 3, width of the AXIS block vector (matches monitor's `axis_block_sigs`)
- `THRESHOLD`, 16, consecutive `block`-high cycles required to declare deadlock; legal range 1..2^CNT_WIDTH-1
- `CNT_WIDTH`, 16, stall counter width
- `TS_WIDTH`, 32, cycle timestamp width

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `block`  in  1  monitor verdict, registered by the monitor
- `axis_block_sigs`  in  AXIS_NUM  per-channel AXIS block status
- `clear`  in  1  abandon/clear any report and sticky flag
- `report_valid`  out  1  report payload valid
- `report_ready`  in  1  logger accepts report
- `report_ts`  out  TS_WIDTH  cycle timestamp of qualification
- `report_axis`  out  AXIS_NUM  snapshot of `axis_block_sigs`
- `report_count`  out  8  accepted reports, saturating at 255
- `deadlock`  out  1  sticky deadlock flag

## Operation
- Free-running `cycle_cnt` (TS_WIDTH) counts from 0 after reset. It increments every cycle and wraps modulo 2^TS_WIDTH. `clear` does not affect it.
- FSM states: IDLE, ARMING, REPORT, HOLD.
- IDLE:
  - `stall_cnt`=0.
  - `block`=1 and THRESHOLD=1: go to REPORT.
  - `block`=1 and THRESHOLD>1: go to ARMING with `stall_cnt`=1.
- ARMING:
  - `block`=0: go to IDLE, `stall_cnt`=0.
  - `block`=1 and `stall_cnt`==THRESHOLD-1: go to REPORT.
  - Otherwise `block`=1: `stall_cnt`+1.
- Qualification snapshot: on any transition into REPORT, `report_axis` is loaded with the current `axis_block_sigs` and `report_ts` with the current `cycle_cnt`.
- REPORT:
  - `report_valid`=1; payload held stable.
  - `block` changes are ignored.
  - `report_valid`&`report_ready`: go to HOLD and increment `report_count` (saturating).
- HOLD: leaves only on `clear`; `block` is ignored. Exactly one report is issued per deadlock episode.
- `deadlock` is 1 in REPORT and HOLD, 0 otherwise.
- `clear`, in any state: next state IDLE, `stall_cnt`=0, `report_valid` drops, `deadlock` drops.
  - `clear` has priority over all transitions, including a same-cycle handshake. That handshake does not count.
  - `report_count` is not reset by `clear`.
  - Deliberate exception: valid may drop without handshake on `clear`.

## Timing
- Reset values:
  - `report_valid`=0, `deadlock`=0, `report_count`=0.
  - `report_ts`=0, `report_axis`=0.
  - State IDLE, `stall_cnt`=0, `cycle_cnt`=0.
- Latency: `block` sampled high at cycles t..t+THRESHOLD-1 → `report_valid` and `deadlock` high at t+THRESHOLD.
- `report_ts` equals `cycle_cnt` at t+THRESHOLD-1.
- Any single `block`=0 sample in ARMING restarts qualification. The next high sample counts as 1.
- Handshake completes on the edge where valid&ready. `report_valid` is low the following cycle. `report_count` is updated the following cycle.
- `report_ready` may be high before valid; no combinational path from `report_ready` to `report_valid`.
- `reset` mid-REPORT or mid-HOLD returns all state to reset values next cycle.
- All outputs are registered.

## Structure
- Package `aesl_deadlock_pkg` holds:
  - the state enum (IDLE/ARMING/REPORT/HOLD, 2-bit encoding);
  - default constants for AXIS_NUM, THRESHOLD, CNT_WIDTH, TS_WIDTH;
  - the report count width (8).
- One natural sub-module: `aesl_deadlock_stall_timer`.
  - Contains the `stall_cnt` counter with inputs `block`, `restart` and output `expired`.
  - The top holds the FSM, `cycle_cnt`, snapshot registers and handshake.

## Test plan
- THRESHOLD=16, `block` high 15 cycles then low, then high 16 cycles, `axis_block_sigs`=3'b101 → no report after the first burst. `report_valid` rises 16 cycles after the second rise. `report_axis`=3'b101 and `report_ts` equals the 16th high cycle's count.
- Report pending, `report_ready` low 5 cycles then high, `block` toggling meanwhile → payload stable for 6 cycles. One handshake, `report_count`=1, `deadlock` stays 1 in HOLD.
- `clear` and `report_ready` asserted together in REPORT → `report_valid`=0 next cycle, `report_count` unchanged, `deadlock`=0, state IDLE.
- THRESHOLD=1, single-cycle `block` pulse → report the next cycle. After `clear` and a second pulse, `report_count`=2.
- 256 report/accept/clear episodes → `report_count` saturates at 255.
- `reset` asserted during REPORT → all outputs 0 the next cycle. `cycle_cnt` restarts at 0 and `report_ts` of the next report reflects the new count.
